mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between instruction fetch (IF) and the data-memory path (DM: lb/lh/sb/sh/lw/sw).
- DM requests win by default. A starvation counter forces an IF grant after STARVE_LIMIT consecutive DM grants.
- Each requester sees a one-cycle ack pulse and uses it to release its pipeline stall.

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared port.
// slave is the arbiter view; master is the requester/memory environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              dm_req;
  logic              dm_we;
  logic [1:0]        dm_mode;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              mem_en;
  logic              mem_we;
  logic [1:0]        mem_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              owner;
  logic              err;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack,
    input  dm_req, dm_we, dm_mode, dm_addr, dm_wdata,
    output dm_rdata, dm_ack,
    output mem_en, mem_we, mem_mode, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output owner, err
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack,
    output dm_req, dm_we, dm_mode, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack,
    input  mem_en, mem_we, mem_mode, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  owner, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and data (DM).
// Define ARB_TIMEOUT_EN to add a grant watchdog that aborts with err.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 15
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, DGNT, IGNT, RESP
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [3:0]        starve_q;
  logic              go_if, go_dm;
  logic              granted, done, abort;
  logic              mem_en_q, mem_we_q;
  logic [1:0]        mem_mode_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              owner_q;
  logic              if_ack_q, dm_ack_q, err_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (granted) begin
      wd_q <= wd_q + 8'd1;
    end else begin
      wd_q <= '0;
    end
  end

  assign abort = granted && !bus.mem_ready
              && (wd_q == 8'(TIMEOUT - 1));
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign abort = 1'b0;
`endif

  always_comb begin
    go_if   = bus.if_req
           && (!bus.dm_req || starve_q == LIMIT);
    go_dm   = bus.dm_req && !go_if;
    granted = (state_q == DGNT) || (state_q == IGNT);
    done    = granted && bus.mem_ready;
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          go_if:   state_d = IGNT;
          go_dm:   state_d = DGNT;
          default: state_d = IDLE;
        endcase
      end
      DGNT, IGNT: begin
        if (done || abort) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_mode_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (go_if) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_mode_q  <= 2'b10;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
            owner_q     <= 1'b1;
            starve_q    <= '0;
          end else if (go_dm) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.dm_we;
            // reserved size code goes out as a word access
            mem_mode_q  <= (bus.dm_mode == 2'b11)
                         ? 2'b10 : bus.dm_mode;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            owner_q     <= 1'b0;
            if (bus.if_req && starve_q != LIMIT)
              starve_q <= starve_q + 4'd1;
          end
        end
        DGNT, IGNT: begin
          if (done || abort) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_mode_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= abort;
            if (owner_q) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= done ? bus.mem_rdata : '0;
            end else begin
              dm_ack_q <= 1'b1;
              if (abort)
                dm_rdata_q <= '0;
              else if (!mem_we_q)
                dm_rdata_q <= bus.mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_mode  = mem_mode_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.owner     = owner_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.err       = err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random traffic against a transaction model.
// Memory and requesters are modelled in the bench; ARB_TIMEOUT_EN adds abort test.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 3;
  localparam int TMO   = 15;

  typedef struct {
    logic        we;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] if_q [$];
  dm_t         dm_q [$];
  bit          grant_log [$];
  bit          ack_log [$];
  bit          if_busy = 0, dm_busy = 0;
  bit          mem_mute = 0, inject_ready = 0, expect_abort = 0;
  int          mem_lat = 1;
  logic [31:0] exp_dm_rdata = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  // Memory responder and grant-level reference model
  bit          prev_en = 0, ready_given = 0, exp_owner;
  int          streak = 0, wait_cnt = 0;
  logic        s_we;
  logic [1:0]  s_mode;
  logic [31:0] s_addr, s_wdata;
  always @(negedge clk) begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = $urandom;
    if (!rst_n) begin
      prev_en = 0; streak = 0;
      wait_cnt = 0; ready_given = 0;
    end else begin
      chk("ack_excl", bus.if_ack & bus.dm_ack, 0);
      if (bus.if_ack | bus.dm_ack)
        chk("ack_err", bus.err, expect_abort);
      else
        chk("idle_err", bus.err, 0);
      if (bus.mem_en && !prev_en) begin
        exp_owner = bus.if_req
                 && (!bus.dm_req || streak == LIMIT);
        chk("grant_owner", bus.owner, exp_owner);
        grant_log.push_back(bus.owner);
        if (exp_owner) begin
          streak = 0;
          chk("g_if_addr", bus.mem_addr, bus.if_addr);
          chk("g_if_we", bus.mem_we, 0);
          chk("g_if_mode", bus.mem_mode, 2'b10);
        end else begin
          if (bus.if_req && streak < LIMIT) streak++;
          chk("g_dm_addr", bus.mem_addr, bus.dm_addr);
          chk("g_dm_we", bus.mem_we, bus.dm_we);
          chk("g_dm_mode", bus.mem_mode,
              bus.dm_mode == 2'b11 ? 2'b10 : bus.dm_mode);
          chk("g_dm_wdata", bus.mem_wdata, bus.dm_wdata);
        end
        s_we = bus.mem_we; s_mode = bus.mem_mode;
        s_addr = bus.mem_addr; s_wdata = bus.mem_wdata;
        wait_cnt = 0; ready_given = 0;
      end else if (bus.mem_en) begin
        chk("hold_we", bus.mem_we, s_we);
        chk("hold_mode", bus.mem_mode, s_mode);
        chk("hold_addr", bus.mem_addr, s_addr);
        chk("hold_wdata", bus.mem_wdata, s_wdata);
      end
      if (bus.mem_en && !ready_given) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat && !mem_mute) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
          ready_given = 1;
        end
      end
      if (inject_ready) bus.mem_ready = 1'b1;
      prev_en = bus.mem_en;
    end
  end

  // Fetch requester
  logic [31:0] if_cur;
  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        bus.if_req = 1'b0; if_busy = 0;
      end else begin
        if (if_busy) begin
          if (bus.if_ack) begin
            chk("if_rdata", bus.if_rdata,
                expect_abort ? 32'h0 : mem_word(if_cur));
            ack_log.push_back(1'b1);
            if_busy = 0; bus.if_req = 1'b0;
          end
        end else begin
          chk("if_idle_ack", bus.if_ack, 0);
        end
        if (!if_busy && if_q.size() > 0) begin
          if_cur = if_q.pop_front();
          bus.if_addr = if_cur; bus.if_req = 1'b1;
          if_busy = 1;
        end
      end
    end
  end

  // Data requester
  dm_t dm_cur;
  initial begin
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_mode = '0;
    bus.dm_addr = '0; bus.dm_wdata = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        bus.dm_req = 1'b0; dm_busy = 0; exp_dm_rdata = 0;
      end else begin
        if (dm_busy) begin
          if (bus.dm_ack) begin
            if (expect_abort) exp_dm_rdata = 0;
            else if (!dm_cur.we) exp_dm_rdata = mem_word(dm_cur.addr);
            chk("dm_rdata", bus.dm_rdata, exp_dm_rdata);
            ack_log.push_back(1'b0);
            dm_busy = 0; bus.dm_req = 1'b0;
          end
        end else begin
          chk("dm_idle_ack", bus.dm_ack, 0);
        end
        if (!dm_busy && dm_q.size() > 0) begin
          dm_cur = dm_q.pop_front();
          bus.dm_we = dm_cur.we; bus.dm_mode = dm_cur.mode;
          bus.dm_addr = dm_cur.addr; bus.dm_wdata = dm_cur.wdata;
          bus.dm_req = 1'b1; dm_busy = 1;
        end
      end
    end
  end

  task automatic drain(string tag, int bound);
    int n = 0;
    bit ok;
    while ((if_q.size() > 0 || dm_q.size() > 0 || if_busy
            || dm_busy || bus.mem_en) && n < bound) begin
      @(negedge clk); #2; n++;
    end
    ok = (n < bound);
    chk(tag, ok, 1);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_en"}, bus.mem_en, 0);
    chk({tag, "_we"}, bus.mem_we, 0);
    chk({tag, "_mode"}, bus.mem_mode, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_acks"}, {bus.if_ack, bus.dm_ack, bus.err}, 0);
    chk({tag, "_owner"}, bus.owner, 0);
    chk({tag, "_if_rd"}, bus.if_rdata, 0);
    chk({tag, "_dm_rd"}, bus.dm_rdata, 0);
  endtask

  initial begin
    int n, en_n, acks;
    bit seen, pat [5];
    dm_t t;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    mem_img[32'h40]   = 32'h8C220004;
    mem_img[32'h1002] = 32'h0000BEEF;
    pat = '{0, 0, 0, 1, 0};

    repeat (3) @(negedge clk); #2;
    chk_reset_outs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk); #2;

    // single fetch, 1-cycle memory
    if_q.push_back(32'h40);
    n = 0; en_n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk); #2; n++;
      if (bus.mem_en) begin
        en_n++;
        chk("t1_we", bus.mem_we, 0);
        chk("t1_mode", bus.mem_mode, 2'b10);
      end
      if (bus.if_ack) begin
        seen = 1;
        chk("t1_rdata", bus.if_rdata, 32'h8C220004);
      end
    end
    chk("t1_lat", n, 3);
    chk("t1_en_cycles", en_n, 1);
    drain("t1_drain", 50);

    // simultaneous requests: DM first, then IF
    grant_log.delete(); ack_log.delete();
    t = '{we: 1'b0, mode: 2'b01, addr: 32'h1002, wdata: 32'h0};
    dm_q.push_back(t);
    if_q.push_back(32'h80);
    drain("t2_drain", 50);
    chk("t2_nacks", ack_log.size(), 2);
    chk("t2_first", ack_log[0], 0);
    chk("t2_second", ack_log[1], 1);
    chk("t2_dm_rdata", bus.dm_rdata, 32'h0000BEEF);

    // starvation: four back-to-back stores with a fetch waiting
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      t = '{we: 1'b1, mode: 2'b10,
            addr: 32'h3000 + 32'(4 * i), wdata: $urandom};
      dm_q.push_back(t);
    end
    if_q.push_back(32'h100);
    drain("t3_drain", 100);
    chk("t3_ngrants", grant_log.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t3_grant%0d", i), grant_log[i], pat[i]);

    // byte store with 5-cycle memory
    mem_lat = 5;
    t = '{we: 1'b1, mode: 2'b00, addr: 32'h2003, wdata: 32'hA5};
    dm_q.push_back(t);
    en_n = 0; acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #2;
      if (bus.mem_en) begin
        en_n++;
        chk("t4_we", bus.mem_we, 1);
        chk("t4_mode", bus.mem_mode, 2'b00);
        chk("t4_addr", bus.mem_addr, 32'h2003);
      end
      if (bus.dm_ack) acks++;
    end
    chk("t4_en_cycles", en_n, 5);
    chk("t4_ack_pulses", acks, 1);
    chk("t4_rdata_keep", bus.dm_rdata, 32'h0000BEEF);
    drain("t4_drain", 50);

    // reset in the middle of a fetch grant
    mem_lat = 4;
    if_q.push_back(32'h300);
    n = 0;
    while (!bus.mem_en && n < 20) begin
      @(negedge clk); #2; n++;
    end
    chk("t5_granted", bus.mem_en, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t5_en_drop", bus.mem_en, 0);
    chk("t5_no_ack", bus.if_ack, 0);
    repeat (2) @(negedge clk); #2;
    chk_reset_outs("t5_rst");
    rst_n = 1'b1;
    inject_ready = 1;
    @(negedge clk); #2;
    inject_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      chk("t5_late_en", bus.mem_en, 0);
      chk("t5_late_ack", bus.if_ack, 0);
    end

`ifdef ARB_TIMEOUT_EN
    // watchdog abort on a memory that never answers
    mem_mute = 1; expect_abort = 1;
    t = '{we: 1'b0, mode: 2'b10, addr: 32'h4000, wdata: 32'h0};
    dm_q.push_back(t);
    n = 0; en_n = 0; seen = 0;
    while (!seen && n < 60) begin
      @(negedge clk); #2; n++;
      if (bus.mem_en) en_n++;
      if (bus.dm_ack) begin
        seen = 1;
        chk("t6_err", bus.err, 1);
        chk("t6_rdata", bus.dm_rdata, 0);
      end
    end
    chk("t6_seen", seen, 1);
    chk("t6_en_cycles", en_n, TMO);
    expect_abort = 0; mem_mute = 0;
    mem_lat = 1;
    if_q.push_back(32'h40);
    drain("t6_recover", 50);
`else
    // without watchdog the grant waits for memory
    mem_mute = 1;
    t = '{we: 1'b0, mode: 2'b10, addr: 32'h5000, wdata: 32'h0};
    dm_q.push_back(t);
    repeat (30) @(negedge clk); #2;
    chk("t6_still_en", bus.mem_en, 1);
    chk("t6_no_ack", bus.dm_ack, 0);
    chk("t6_no_err", bus.err, 0);
    mem_mute = 0;
    drain("t6_drain", 50);
`endif

    // random mixed traffic
    for (int r = 0; r < 4; r++) begin
      mem_lat = $urandom_range(1, 4);
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 3) != 0)
          if_q.push_back($urandom & 32'hFFFF_FFFC);
        t.we = 1'($urandom_range(0, 1));
        t.mode = 2'($urandom_range(0, 3));
        t.addr = $urandom;
        t.wdata = $urandom;
        if ($urandom_range(0, 3) != 0) dm_q.push_back(t);
      end
      drain($sformatf("rnd%0d_drain", r), 2000);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
